// File: rtl/trap_arbiter_if.sv
// ---------------------------------------------------------------------------
// trap_arbiter_if
// Bundle between the commit stage, the interrupt lines, the CSR unit and the
// trap arbiter.
//   commit_*       retiring-instruction information (commit stage -> arbiter)
//   irq            raw asynchronous level interrupt lines
//   mstatus_mie    global interrupt enable
//   mie            per-cause interrupt enable
//   trap_req/ack   req/ack handshake with the CSR unit
//   trap_is_int    trap is an interrupt
//   trap_cause     mcause value
//   trap_epc       mepc value
//   flush / stall  pipeline control outputs
// modport master : environment side (drives inputs, observes outputs)
// modport slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface trap_arbiter_if #(
    parameter int NUM_INT = 3,
    parameter int XLEN    = 64
);
    logic               commit_valid;
    logic [XLEN-1:0]    commit_pc;
    logic [XLEN-1:0]    commit_npc;
    logic               commit_ex;
    logic [3:0]         commit_ex_code;
    logic               commit_ecall;
    logic               commit_serial;
    logic [NUM_INT-1:0] irq;
    logic               mstatus_mie;
    logic [XLEN-1:0]    mie;
    logic               trap_req;
    logic               trap_ack;
    logic               trap_is_int;
    logic [XLEN-1:0]    trap_cause;
    logic [XLEN-1:0]    trap_epc;
    logic               flush;
    logic               stall;

    modport master (
        output commit_valid, commit_pc, commit_npc, commit_ex, commit_ex_code,
               commit_ecall, commit_serial, irq, mstatus_mie, mie, trap_ack,
        input  trap_req, trap_is_int, trap_cause, trap_epc, flush, stall
    );

    modport slave (
        input  commit_valid, commit_pc, commit_npc, commit_ex, commit_ex_code,
               commit_ecall, commit_serial, irq, mstatus_mie, mie, trap_ack,
        output trap_req, trap_is_int, trap_cause, trap_epc, flush, stall
    );
endinterface

// File: rtl/trap_arbiter.sv
// ---------------------------------------------------------------------------
// trap_arbiter
// Commit-stage trap arbiter. Merges commit-stage exceptions with NUM_INT
// synchronised interrupt lines and issues one trap at a time to the CSR unit
// over a req/ack handshake, while driving the pipeline flush and commit stall.
// Ports:
//   clk    clock
//   reset  asynchronous, active-low reset
//   bus    trap_arbiter_if.slave (commit info, irq lines, enables, CSR
//          handshake, trap cause/epc, flush, stall)
// Parameters:
//   NUM_INT      interrupt lines, index 0 has the highest priority
//   INT_CAUSE    mcause code per line, also selects the mie bit
//   SYNC_STAGES  synchroniser flops per irq line (>= 1)
//   XLEN         data/address width
// ---------------------------------------------------------------------------
module trap_arbiter #(
    parameter int                         NUM_INT     = 3,
    parameter logic [NUM_INT-1:0][5:0]    INT_CAUSE   = {6'd7, 6'd3, 6'd11},
    parameter int                         SYNC_STAGES = 2,
    parameter int                         XLEN        = 64
) (
    input  logic          clk,
    input  logic          reset,
    trap_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRAP  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               req_q, req_d;
    logic               flush_q, flush_d;
    logic               stall_q, stall_d;
    logic               is_int_q, is_int_d;
    logic [XLEN-1:0]    cause_q, cause_d;
    logic [XLEN-1:0]    epc_q, epc_d;

    logic [NUM_INT-1:0] sync_q [SYNC_STAGES];
    logic [NUM_INT-1:0] irq_s;
    logic [NUM_INT-1:0] pend;
    logic               int_hit;
    logic [5:0]         int_code;
    logic               ex;
    logic               take_int;
    logic               accept;
    logic [XLEN-1:0]    cause_sel;
    logic [XLEN-1:0]    epc_sel;

    // Interrupt synchroniser chain; stage 0 samples the raw asynchronous line.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its input from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= bus.irq;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign irq_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        for (int i = 0; i < NUM_INT; i++) begin
            pend[i] = irq_s[i] & bus.mie[INT_CAUSE[i]] & bus.mstatus_mie;
        end
    end

    // Priority pick: scanning from the highest index down leaves the lowest
    // pending index as the winner.
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        int_hit  = 1'b0;
        int_code = '0;
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (pend[i]) begin
                int_hit  = 1'b1;
                int_code = INT_CAUSE[i];
            end
        end
    end

    assign ex       = bus.commit_ex | bus.commit_ecall;
    assign take_int = int_hit & ~ex;
    // stall_q is never set in IDLE; qualifying with it keeps a commit that
    // violates the stall from ever being accepted.
    assign accept   = (state_q == IDLE) & bus.commit_valid & ~stall_q;

    // An explicit exception code takes precedence over the ECALL cause.
    always_comb begin
        if (bus.commit_ex) begin
            cause_sel = XLEN'(bus.commit_ex_code);
        end else if (bus.commit_ecall) begin
            cause_sel = XLEN'(4'd11);
        end else begin
            cause_sel            = XLEN'(int_code);
            cause_sel[XLEN-1]    = 1'b1;
        end
    end

    // An interrupted instruction has retired, so the return point is its npc.
    assign epc_sel = ex ? bus.commit_pc : bus.commit_npc;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        flush_d  = 1'b0;
        stall_d  = stall_q;
        is_int_d = is_int_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        case (state_q)
            IDLE: begin
                stall_d = 1'b0;
                if (accept && (ex || take_int)) begin
                    state_d  = TRAP;
                    req_d    = 1'b1;
                    flush_d  = 1'b1;
                    stall_d  = 1'b1;
                    is_int_d = take_int;
                    cause_d  = cause_sel;
                    epc_d    = epc_sel;
                end else if (accept && bus.commit_serial) begin
                    // A serialising commit that also traps is covered by the
                    // trap flush above, so only one pulse is ever produced.
                    flush_d = 1'b1;
                end
            end
            TRAP: begin
                stall_d = 1'b1;
                if (bus.trap_ack) begin
                    req_d   = 1'b0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // stall_q is still 1 during this cycle; it drops entering IDLE.
                stall_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
                stall_d = 1'b0;
            end
        endcase
    end

    // NOTE: the latched cause/epc registers are plain datapath flops, but they
    // are reset anyway so every output reads 0 out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            flush_q  <= 1'b0;
            stall_q  <= 1'b0;
            is_int_q <= 1'b0;
            cause_q  <= '0;
            epc_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            flush_q  <= flush_d;
            stall_q  <= stall_d;
            is_int_q <= is_int_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
        end
    end

    assign bus.trap_req    = req_q;
    assign bus.flush       = flush_q;
    assign bus.stall       = stall_q;
    assign bus.trap_is_int = is_int_q;
    assign bus.trap_cause  = cause_q;
    assign bus.trap_epc    = epc_q;

    // Retiring while the commit stage is held is a protocol error.
    a_no_commit_in_stall: assert property (
        @(posedge clk) disable iff (!reset) !(bus.commit_valid && stall_q)
    );

endmodule

// File: tb/tb_trap_arbiter.sv
module tb_trap_arbiter;

    localparam int NUM_INT = 3;
    localparam int XLEN    = 64;

    typedef struct packed {
        logic        req;
        logic        flush;
        logic        stall;
        logic        is_int;
        logic [63:0] cause;
        logic [63:0] epc;
    } trap_t;

    typedef struct {
        bit          trap;
        bit          is_int;
        bit          flush;
        logic [63:0] cause;
        logic [63:0] epc;
    } exp_t;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    trap_arbiter_if #(.NUM_INT(NUM_INT), .XLEN(XLEN)) bus ();

    trap_arbiter #(.NUM_INT(NUM_INT), .SYNC_STAGES(2), .XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [63:0] MIE_ALL = (64'd1 << 11) | (64'd1 << 3) | (64'd1 << 7);

    function automatic trap_t snap();
        return {bus.trap_req, bus.flush, bus.stall, bus.trap_is_int,
                bus.trap_cause, bus.trap_epc};
    endfunction

    function automatic logic [2:0] ctl();
        return {bus.trap_req, bus.flush, bus.stall};
    endfunction

    // Reference model: what a single commit should produce, straight from the
    // priority rules (exception, then lowest pending interrupt line, then
    // serialising flush).
    function automatic exp_t model(bit valid, bit ex, bit ecall, bit serial,
                                   logic [3:0] code, logic [2:0] irq,
                                   logic [63:0] mie, bit gie,
                                   logic [63:0] pc, logic [63:0] npc);
        int   cause_tab [3] = '{11, 3, 7};
        exp_t r;
        r.trap = 0; r.is_int = 0; r.flush = 0; r.cause = '0; r.epc = '0;
        if (!valid) return r;
        if (ex || ecall) begin
            r.trap  = 1;
            r.flush = 1;
            r.cause = ex ? 64'(code) : 64'd11;
            r.epc   = pc;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!r.trap && irq[i] && gie && mie[cause_tab[i]]) begin
                    r.trap   = 1;
                    r.is_int = 1;
                    r.flush  = 1;
                    r.cause  = 64'h8000_0000_0000_0000 + 64'(cause_tab[i]);
                    r.epc    = npc;
                end
            end
        end
        if (!r.trap && serial) r.flush = 1;
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_sync();
        repeat (3) step();
    endtask

    // Drives one commit cycle and returns at the following negedge, i.e. in
    // the first cycle where the registered response is visible.
    task automatic do_commit(bit valid, logic [63:0] pc, logic [63:0] npc,
                             bit ex, logic [3:0] code, bit ecall, bit serial);
        bus.commit_valid   = valid;
        bus.commit_pc      = pc;
        bus.commit_npc     = npc;
        bus.commit_ex      = ex;
        bus.commit_ex_code = code;
        bus.commit_ecall   = ecall;
        bus.commit_serial  = serial;
        step();
        bus.commit_valid   = 1'b0;
        bus.commit_ex      = 1'b0;
        bus.commit_ecall   = 1'b0;
        bus.commit_serial  = 1'b0;
    endtask

    task automatic test_reset();
        trap_t got;
        trap_t want;
        reset              = 1'b0;
        bus.commit_valid   = 1'b0;
        bus.commit_pc      = '0;
        bus.commit_npc     = '0;
        bus.commit_ex      = 1'b0;
        bus.commit_ex_code = '0;
        bus.commit_ecall   = 1'b0;
        bus.commit_serial  = 1'b0;
        bus.irq            = '0;
        bus.mstatus_mie    = 1'b0;
        bus.mie            = '0;
        bus.trap_ack       = 1'b0;
        repeat (3) step();
        got  = snap();
        want = '0;
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL reset_state: got %h want %h", got, want);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_ecall();
        trap_t got;
        trap_t want;
        do_commit(1, 64'h8000_0010, 64'h8000_0014, 0, 4'd0, 1, 0);
        got  = snap();
        want = {1'b1, 1'b1, 1'b1, 1'b0, 64'd11, 64'h8000_0010};
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL ecall_trap: got %h want %h", got, want);
        end
        bus.trap_ack = 1'b1;
        step();
        bus.trap_ack = 1'b0;
        tests_run++;
        if (ctl() !== 3'b001) begin
            tests_failed++;
            $display("FAIL ecall_drain: got req/flush/stall %b want 001", ctl());
        end
        step();
        tests_run++;
        if (ctl() !== 3'b000) begin
            tests_failed++;
            $display("FAIL ecall_idle: got req/flush/stall %b want 000", ctl());
        end
    endtask

    task automatic test_irq();
        trap_t got;
        trap_t want;
        bus.irq         = 3'b100;
        bus.mie         = 64'd1 << 7;
        bus.mstatus_mie = 1'b1;
        wait_sync();
        do_commit(1, 64'h8000_0100, 64'h8000_0104, 0, 4'd0, 0, 0);
        got  = snap();
        want = {1'b1, 1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_0007, 64'h8000_0104};
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL irq_mti: got %h want %h", got, want);
        end
        bus.trap_ack = 1'b1;
        step();
        bus.trap_ack = 1'b0;
        bus.irq      = '0;
        step();
        wait_sync();
    endtask

    task automatic test_ex_beats_int();
        trap_t got;
        trap_t want;
        bus.irq         = 3'b111;
        bus.mie         = MIE_ALL;
        bus.mstatus_mie = 1'b1;
        wait_sync();
        do_commit(1, 64'h8000_0200, 64'h8000_0204, 1, 4'd2, 0, 0);
        got  = snap();
        want = {1'b1, 1'b1, 1'b1, 1'b0, 64'd2, 64'h8000_0200};
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL ex_over_int: got %h want %h", got, want);
        end
        bus.trap_ack = 1'b1;
        step();
        bus.trap_ack = 1'b0;
        step();
        do_commit(1, 64'h8000_0300, 64'h8000_0304, 0, 4'd0, 0, 0);
        got  = snap();
        want = {1'b1, 1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_000B, 64'h8000_0304};
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL int_after_ex: got %h want %h", got, want);
        end
        bus.trap_ack = 1'b1;
        step();
        bus.trap_ack = 1'b0;
        bus.irq      = '0;
        step();
        wait_sync();
    endtask

    task automatic test_hold();
        trap_t got;
        trap_t want;
        do_commit(1, 64'h8000_0400, 64'h8000_0404, 1, 4'd5, 1, 0);
        want = {1'b1, 1'b1, 1'b1, 1'b0, 64'd5, 64'h8000_0400};
        got  = snap();
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL hold_first: got %h want %h", got, want);
        end
        want.flush = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            got = snap();
            tests_run++;
            if (got !== want) begin
                tests_failed++;
                $display("FAIL hold_cycle%0d: got %h want %h", c, got, want);
            end
        end
        bus.trap_ack = 1'b1;
        step();
        bus.trap_ack = 1'b0;
        tests_run++;
        if (ctl() !== 3'b001) begin
            tests_failed++;
            $display("FAIL hold_drain: got req/flush/stall %b want 001", ctl());
        end
        step();
        tests_run++;
        if (ctl() !== 3'b000) begin
            tests_failed++;
            $display("FAIL hold_idle: got req/flush/stall %b want 000", ctl());
        end
    endtask

    task automatic test_serial();
        trap_t got;
        trap_t want;
        bus.irq = '0;
        wait_sync();
        do_commit(1, 64'h8000_0500, 64'h8000_0504, 0, 4'd0, 0, 1);
        tests_run++;
        if (ctl() !== 3'b010) begin
            tests_failed++;
            $display("FAIL serial_flush: got req/flush/stall %b want 010", ctl());
        end
        step();
        tests_run++;
        if (ctl() !== 3'b000) begin
            tests_failed++;
            $display("FAIL serial_single: got req/flush/stall %b want 000", ctl());
        end
        // Global enable off: pending lines must not trap.
        bus.mstatus_mie = 1'b0;
        bus.mie         = MIE_ALL;
        bus.irq         = 3'b111;
        wait_sync();
        do_commit(1, 64'h8000_0600, 64'h8000_0604, 0, 4'd0, 0, 1);
        tests_run++;
        if (ctl() !== 3'b010) begin
            tests_failed++;
            $display("FAIL serial_gie_off: got req/flush/stall %b want 010", ctl());
        end
        step();
        // Serialising commit with an interrupt: trap taken, one flush only.
        bus.mstatus_mie = 1'b1;
        do_commit(1, 64'h8000_0700, 64'h8000_0704, 0, 4'd0, 0, 1);
        got  = snap();
        want = {1'b1, 1'b1, 1'b1, 1'b1, 64'h8000_0000_0000_000B, 64'h8000_0704};
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL serial_int_trap: got %h want %h", got, want);
        end
        step();
        tests_run++;
        if (ctl() !== 3'b101) begin
            tests_failed++;
            $display("FAIL serial_int_one_flush: got req/flush/stall %b want 101", ctl());
        end
        bus.trap_ack = 1'b1;
        step();
        bus.trap_ack = 1'b0;
        step();
        // A pulse that is gone by the commit boundary is lost.
        bus.irq = 3'b010;
        wait_sync();
        bus.irq = 3'b000;
        wait_sync();
        do_commit(1, 64'h8000_0800, 64'h8000_0804, 0, 4'd0, 0, 0);
        tests_run++;
        if (ctl() !== 3'b000) begin
            tests_failed++;
            $display("FAIL lost_irq: got req/flush/stall %b want 000", ctl());
        end
        step();
    endtask

    task automatic test_reset_mid_trap();
        do_commit(1, 64'h8000_0900, 64'h8000_0904, 0, 4'd0, 1, 0);
        step();
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (ctl() !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_mid_trap: got req/flush/stall %b want 000", ctl());
        end
        step();
        reset   = 1'b1;
        bus.irq = '0;
        step();
        do_commit(1, 64'h8000_0a00, 64'h8000_0a04, 0, 4'd0, 0, 0);
        tests_run++;
        if (ctl() !== 3'b000) begin
            tests_failed++;
            $display("FAIL post_reset_commit: got req/flush/stall %b want 000", ctl());
        end
        step();
        tests_run++;
        if (ctl() !== 3'b000) begin
            tests_failed++;
            $display("FAIL post_reset_quiet: got req/flush/stall %b want 000", ctl());
        end
    endtask

    task automatic test_random();
        exp_t        e;
        trap_t       got;
        trap_t       want;
        logic [63:0] pc;
        bit          valid, ex, ecall, serial;
        logic [3:0]  code;
        int          hold;
        for (int n = 0; n < 60; n++) begin
            bus.irq         = 3'($urandom_range(0, 7));
            bus.mie         = (($urandom_range(0, 1) != 0) ? (64'd1 << 11) : 64'd0)
                            | (($urandom_range(0, 1) != 0) ? (64'd1 << 3)  : 64'd0)
                            | (($urandom_range(0, 1) != 0) ? (64'd1 << 7)  : 64'd0);
            bus.mstatus_mie = ($urandom_range(0, 3) != 0);
            for (int w = 0; w < 3; w++) begin
                // Acks while idle must be ignored.
                bus.trap_ack = ($urandom_range(0, 1) != 0);
                step();
            end
            bus.trap_ack = 1'b0;
            pc     = {32'h8000_0000, $urandom} & ~64'd3;
            valid  = ($urandom_range(0, 9) != 0);
            ex     = ($urandom_range(0, 3) == 0);
            ecall  = ($urandom_range(0, 3) == 0);
            serial = ($urandom_range(0, 3) == 0);
            code   = 4'($urandom_range(0, 15));
            e = model(valid, ex, ecall, serial, code, bus.irq, bus.mie,
                      bus.mstatus_mie, pc, pc + 64'd4);
            do_commit(valid, pc, pc + 64'd4, ex, code, ecall, serial);
            if (e.trap) begin
                want = {1'b1, 1'b1, 1'b1, e.is_int, e.cause, e.epc};
                got  = snap();
                tests_run++;
                if (got !== want) begin
                    tests_failed++;
                    $display("FAIL rand%0d_trap: got %h want %h", n, got, want);
                end
                want.flush = 1'b0;
                hold = $urandom_range(0, 3);
                for (int h = 0; h < hold; h++) begin
                    step();
                    got = snap();
                    tests_run++;
                    if (got !== want) begin
                        tests_failed++;
                        $display("FAIL rand%0d_hold: got %h want %h", n, got, want);
                    end
                end
                bus.trap_ack = 1'b1;
                step();
                bus.trap_ack = 1'b0;
                tests_run++;
                if (ctl() !== 3'b001) begin
                    tests_failed++;
                    $display("FAIL rand%0d_drain: got req/flush/stall %b want 001", n, ctl());
                end
            end else begin
                tests_run++;
                if (ctl() !== {1'b0, e.flush, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL rand%0d_notrap: got req/flush/stall %b want %b",
                             n, ctl(), {1'b0, e.flush, 1'b0});
                end
            end
            step();
            tests_run++;
            if (ctl() !== 3'b000) begin
                tests_failed++;
                $display("FAIL rand%0d_idle: got req/flush/stall %b want 000", n, ctl());
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_ecall();
        test_irq();
        test_ex_beats_int();
        test_hold();
        test_serial();
        test_reset_mid_trap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
